// File: rtl/prod_accum.sv
// Block accumulator for the multiply-stage product stream: sums N_SAMPLES products per start
// pulse and presents each sum on a valid/ready register. `define PROD_ACCUM_MAX_EN adds out_max.
module prod_accum #(
  parameter int N_SAMPLES = 4,
  parameter int ACC_W     = 10
) (
  input  logic             clk,
  input  logic             res,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             start,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PROD_ACCUM_MAX_EN
  output logic [7:0]       out_max,
`endif
  output logic             busy,
  output logic             drop_err
);

  localparam int CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] pend;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] sum_next;
  logic             drain;
  logic             slot_free;

  assign sum_next  = acc + ACC_W'(in_data);
  assign drain     = out_valid && out_ready;
  assign slot_free = !out_valid || out_ready;

`ifdef PROD_ACCUM_MAX_EN
  logic [7:0] max_cur;
  logic [7:0] max_pend;
  logic [7:0] max_next;

  assign max_next = (in_data > max_cur) ? in_data : max_cur;
`endif

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      pend      <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      drop_err  <= 1'b0;
`ifdef PROD_ACCUM_MAX_EN
      max_cur   <= '0;
      max_pend  <= '0;
      out_max   <= '0;
`endif
    end else begin
      // A handshake empties the slot; a completion below may refill it on the same edge.
      if (drain) out_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            state <= ACCUM;
            busy  <= 1'b1;
            acc   <= '0;
            cnt   <= '0;
`ifdef PROD_ACCUM_MAX_EN
            max_cur <= '0;
`endif
          end
        end

        ACCUM: begin
          if (in_valid) begin
            if (cnt == LAST) begin
              if (slot_free) begin
                out_sum   <= sum_next;
                out_valid <= 1'b1;
                state     <= IDLE;
                busy      <= 1'b0;
`ifdef PROD_ACCUM_MAX_EN
                out_max   <= max_next;
`endif
              end else begin
                pend  <= sum_next;
                state <= STALL;
`ifdef PROD_ACCUM_MAX_EN
                max_pend <= max_next;
`endif
              end
            end else begin
              acc <= sum_next;
              cnt <= cnt + CNT_W'(1);
`ifdef PROD_ACCUM_MAX_EN
              max_cur <= max_next;
`endif
            end
          end
        end

        STALL: begin
          if (in_valid) drop_err <= 1'b1;
          if (drain) begin
            out_sum   <= pend;
            out_valid <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
`ifdef PROD_ACCUM_MAX_EN
            out_max   <= max_pend;
`endif
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Directed self-checking bench for prod_accum (N_SAMPLES=4, ACC_W=10); out_max is
// checked as well when PROD_ACCUM_MAX_EN is defined.
module tb_prod_accum;

  logic       clk = 1'b0;
  logic       res;
  logic [7:0] in_data;
  logic       in_valid;
  logic       start;
  logic [9:0] out_sum;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       drop_err;
`ifdef PROD_ACCUM_MAX_EN
  logic [7:0] out_max;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  prod_accum #(.N_SAMPLES(4), .ACC_W(10)) dut (
    .clk       (clk),
    .res       (res),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .start     (start),
    .out_sum   (out_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PROD_ACCUM_MAX_EN
    .out_max   (out_max),
`endif
    .busy      (busy),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one clock edge; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 8'd0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    res = 1'b1; in_data = 8'd0; in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    tick(); tick();
    res = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum",   out_sum,   0);
    check("rst_busy",      busy,      0);
    check("rst_drop_err",  drop_err,  0);

    // Basic block 1+2+3+4
    pulse_start();
    check("basic_busy_on", busy, 1);
    send(1, 8'd1); send(1, 8'd2); send(1, 8'd3);
    check("basic_no_early_valid", out_valid, 0);
    send(1, 8'd4);
    check("basic_valid", out_valid, 1);
    check("basic_sum",   out_sum,   10);
    check("basic_busy_off", busy, 0);
`ifdef PROD_ACCUM_MAX_EN
    check("basic_max", out_max, 4);
`endif
    tick();
    check("basic_valid_clears", out_valid, 0);

    // Full-scale products
    pulse_start();
    for (int i = 0; i < 4; i++) send(1, 8'd225);
    check("max_valid", out_valid, 1);
    check("max_sum",   out_sum,   900);
`ifdef PROD_ACCUM_MAX_EN
    check("max_max", out_max, 225);
`endif
    tick();

    // Gapped input 5,_,_,7,_,9,11
    pulse_start();
    send(1, 8'd5); send(0, 8'd0); send(0, 8'd0); send(1, 8'd7);
    send(0, 8'd0); send(1, 8'd9);
    check("gap_busy", busy, 1);
    check("gap_no_valid", out_valid, 0);
    send(1, 8'd11);
    check("gap_valid", out_valid, 1);
    check("gap_sum",   out_sum,   32);
    tick();

    // Product on the start cycle is not accumulated
    start = 1'b1; in_valid = 1'b1; in_data = 8'd50;
    tick();
    start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) send(1, 8'd1);
    check("coll_valid", out_valid, 1);
    check("coll_sum",   out_sum,   4);
    tick();

    // Products in IDLE without start are ignored
    for (int i = 0; i < 5; i++) send(1, 8'd1);
    check("idle_no_valid", out_valid, 0);
    check("idle_busy",     busy,      0);

    // Back-pressure: second block stalls behind an unconsumed result
    out_ready = 1'b0;
    pulse_start();
    send(1, 8'd1); send(1, 8'd2); send(1, 8'd3); send(1, 8'd4);
    check("bp_blk1_valid", out_valid, 1);
    check("bp_blk1_sum",   out_sum,   10);
    pulse_start();
    for (int i = 0; i < 4; i++) send(1, 8'd2);
    check("bp_stall_busy", busy,     1);
    check("bp_stall_sum",  out_sum,  10);
    check("bp_stall_valid", out_valid, 1);
    check("bp_no_drop_yet", drop_err, 0);
`ifdef PROD_ACCUM_MAX_EN
    check("bp_stall_max", out_max, 4);
`endif
    send(1, 8'd3);
    check("bp_drop_err", drop_err, 1);
    check("bp_still_10", out_sum,  10);
    out_ready = 1'b1;
    tick();
    check("bp_reload_sum",   out_sum,   8);
    check("bp_reload_valid", out_valid, 1);
    check("bp_idle",         busy,      0);
`ifdef PROD_ACCUM_MAX_EN
    check("bp_reload_max", out_max, 2);
`endif
    tick();
    check("bp_second_hs", out_valid, 0);
    check("bp_drop_sticky", drop_err, 1);

    // Reset mid-block discards the partial sum and clears drop_err
    pulse_start();
    send(1, 8'd9); send(1, 8'd9);
    res = 1'b1;
    tick();
    res = 1'b0;
    check("mid_rst_busy",  busy,      0);
    check("mid_rst_drop",  drop_err,  0);
    check("mid_rst_valid", out_valid, 0);
    pulse_start();
    send(1, 8'd1); send(1, 8'd2); send(1, 8'd3); send(1, 8'd4);
    check("mid_rst_sum",   out_sum,   10);
    check("mid_rst_valid2", out_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
Name: prod_accum

Overview:
- Downstream consumer of the 4x4 multiply stage.
- Collects the stage's 8-bit unsigned product stream and sums blocks of N_SAMPLES products.
- Presents each block sum on a valid/ready output register.
- Flags samples lost while the output path is back-pressured.

Parameters:
N_SAMPLES, 4, products per block; power of two, range 2..16
ACC_W, 10, sum width; must be >= 8 + log2(N_SAMPLES) so that N*225 never overflows

Ports:
clk  input  1  clock; all logic on rising edge
res  input  1  synchronous, active-high reset
in_data  input  8  unsigned product from the multiply stage (raw data_out, not the complement form)
in_valid  input  1  in_data is a new product this cycle; one cycle per product
start  input  1  single-cycle pulse; arms accumulation of one block
out_sum  output  ACC_W  block sum
out_valid  output  1  out_sum holds an unconsumed result
out_ready  input  1  consumer accepts out_sum when out_valid && out_ready
busy  output  1  high in ACCUM or STALL
drop_err  output  1  sticky: a product arrived in STALL and was lost

Behaviour:
- Reset: res=1 at a clk edge sets state IDLE and clears acc, cnt, pend and every output to 0.
- Reset overrides all other inputs, including mid-block; a partial sum is discarded.
- States: IDLE, ACCUM, STALL.
- IDLE:
  - in_valid is ignored.
  - start=1 -> ACCUM; acc=0, cnt=0.
  - A product on the same cycle as start is NOT accumulated.
- ACCUM:
  - Each in_valid adds {zeros, in_data} to acc and increments cnt.
  - start is ignored.
  - A product with cnt==N_SAMPLES-1 completes the block; final = acc + in_data.
  - Completion with slot free (out_valid==0, or out_valid && out_ready this cycle): out_sum<=final, out_valid<=1 next cycle, -> IDLE.
  - Completion with slot occupied and not draining: pend<=final, -> STALL.
- STALL:
  - When out_valid && out_ready: out_sum<=pend, out_valid stays 1, -> IDLE.
  - in_valid in STALL: product discarded, drop_err<=1.
  - start is ignored.
- Output handshake:
  - out_valid, once set, holds with out_sum stable until out_valid && out_ready.
  - On that handshake out_valid clears the next cycle, unless it is reloaded the same cycle.
- Latency: out_sum and out_valid are visible one clk after the accepting edge of the last product.
- Back-to-back blocks: the next block needs a fresh start pulse, at least one cycle after the return to IDLE.
- drop_err clears only on res.
- busy = (state != IDLE), registered with state.
- Arithmetic: unsigned and zero-extended; no saturation needed given the ACC_W rule.

Optional Feature:
- Macro: PROD_ACCUM_MAX_EN.
- When defined:
  - Adds output out_max (8 bits), the largest in_data accepted in the block.
  - out_max updates and holds together with out_sum and is carried through STALL via a pending copy.
  - Resets to 0 and is cleared to 0 at start.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic block (N_SAMPLES=4): res, start, in_valid with 1,2,3,4 on consecutive cycles, out_ready=1 -> out_valid pulses one cycle after the 4th product, out_sum=10, busy falls to 0; with MAX_EN, out_max=4.
- Max values: products 225,225,225,225 -> out_sum=900, no wrap within ACC_W=10.
- Gapped input: products 5,_,_,7,_,9,11 (gaps are in_valid=0) -> out_sum=32; idle cycles do not advance cnt.
- Start/data collision and IDLE gating:
  - in_valid=1 with in_data=50 in the same cycle as start, then 1,1,1,1 -> out_sum=4.
  - Products sent while IDLE without start -> no out_valid.
- Back-pressure:
  - Block 1 sums 10, out_ready held 0; start, block 2 of 2,2,2,2 -> STALL, out_sum still 10.
  - Extra product in STALL -> drop_err=1.
  - Raise out_ready -> next cycle out_sum=8, out_valid stays 1, state IDLE; second handshake clears out_valid.
- Reset mid-block: start, products 9,9, res pulse, then start, 1,2,3,4 -> out_sum=10, drop_err=0, no stale contribution.
